// File: rtl/cpu_arb_pkg.sv
// Shared types and helpers for the multi-cpu data channel arbiter.
package cpu_arb_pkg;

    localparam int DATA_W_DEFAULT = 64;
    localparam int SRC_W_MAX      = 4;

    typedef logic [DATA_W_DEFAULT-1:0] data_t;

    typedef struct packed {
        data_t                data;
        logic [SRC_W_MAX-1:0] src;
    } out_word_t;

    function automatic int src_width(input int n);
        if ($clog2(n) < 1) return 1;
        return $clog2(n);
    endfunction

endpackage

// File: rtl/cpu_arb_fifo.sv
// Per-cpu first-word-fall-through FIFO; rdata shows the head with zero latency.
// Push is dropped when full, pop is ignored when empty.
module cpu_arb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_wr_en;
    logic             w_rd_en;

    // Extra MSB on each pointer separates a full ring from an empty one.
    assign empty   = (r_wr_ptr == r_rd_ptr);
    assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_wr_en = push && !full;
    assign w_rd_en = pop && !empty;
    assign rdata   = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/cpu_data_arbiter.sv
// Round-robin merge of NUM_CPU word streams into one registered valid/ready channel.
// One cycle FIFO-to-output; output holds while out_vld && !out_rdy, in_rdy drops only when a FIFO is full.
module cpu_data_arbiter
    import cpu_arb_pkg::*;
#(
    parameter  int NUM_CPU    = 4,
    parameter  int FIFO_DEPTH = 4,
    parameter  int DATA_W     = DATA_W_DEFAULT,
    localparam int SRC_W      = src_width(NUM_CPU)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CPU-1:0]        in_vld,
    input  logic [NUM_CPU*DATA_W-1:0] in_data,
    output logic [NUM_CPU-1:0]        in_rdy,
    input  logic [NUM_CPU-1:0]        in_done,
    output logic                      out_vld,
    output logic [DATA_W-1:0]         out_data,
    output logic [SRC_W-1:0]          out_src,
    input  logic                      out_rdy,
    output logic                      all_done
);
    logic [NUM_CPU-1:0] w_full;
    logic [NUM_CPU-1:0] w_empty;
    logic [NUM_CPU-1:0] w_push;
    logic [NUM_CPU-1:0] w_pop;
    logic [DATA_W-1:0]  w_rdata [NUM_CPU];
    logic               w_load;
    logic [SRC_W:0]     w_pick;
    logic               w_grant_vld;
    logic [SRC_W-1:0]   w_grant_idx;

    logic               r_out_vld;
    logic [DATA_W-1:0]  r_out_data;
    logic [SRC_W-1:0]   r_out_src;
    logic [SRC_W-1:0]   r_rr_ptr;
    logic [NUM_CPU-1:0] r_done_seen;
    logic               r_all_done;

    // Scans downward so the candidate nearest to ptr+1 is the last one written.
    function automatic logic [SRC_W:0] rr_pick(input logic [NUM_CPU-1:0] req,
                                               input logic [SRC_W-1:0]   ptr);
        logic [SRC_W:0] res;
        int             idx;
        res = '0;
        for (int off = NUM_CPU; off >= 1; off--) begin
            idx = (int'(ptr) + off) % NUM_CPU;
            if (req[idx]) res = {1'b1, SRC_W'(idx)};
        end
        return res;
    endfunction

    assign in_rdy      = ~w_full;
    assign w_push      = in_vld & ~w_full;
    assign w_load      = !r_out_vld || out_rdy;
    assign w_pick      = rr_pick(~w_empty, r_rr_ptr);
    assign w_grant_vld = w_pick[SRC_W];
    assign w_grant_idx = w_pick[SRC_W-1:0];

    always_comb begin
        w_pop = '0;
        if (w_load && w_grant_vld) w_pop[w_grant_idx] = 1'b1;
    end

    for (genvar g = 0; g < NUM_CPU; g++) begin : g_fifo
        cpu_arb_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (DATA_W)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (w_push[g]),
            .wdata (in_data[g*DATA_W +: DATA_W]),
            .pop   (w_pop[g]),
            .rdata (w_rdata[g]),
            .full  (w_full[g]),
            .empty (w_empty[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
            r_out_src  <= '0;
            r_rr_ptr   <= SRC_W'(NUM_CPU - 1);
        end else if (w_load) begin
            if (w_grant_vld) begin
                r_out_vld  <= 1'b1;
                r_out_data <= w_rdata[w_grant_idx];
                r_out_src  <= w_grant_idx;
                r_rr_ptr   <= w_grant_idx;
            end else begin
                r_out_vld  <= 1'b0;
            end
        end
    end

    // all_done falls again if anything is pushed after every cpu reported done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done_seen <= '0;
            r_all_done  <= 1'b0;
        end else begin
            r_done_seen <= r_done_seen | in_done;
            r_all_done  <= (&r_done_seen) && (&w_empty) && !r_out_vld;
        end
    end

    assign out_vld  = r_out_vld;
    assign out_data = r_out_data;
    assign out_src  = r_out_src;
    assign all_done = r_all_done;

endmodule

// File: tb/tb_cpu_data_arbiter.sv
// Directed self-checking bench for cpu_data_arbiter (NUM_CPU=4, FIFO_DEPTH=4, DATA_W=64).
module tb_cpu_data_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   in_vld;
    logic [255:0] in_data;
    logic [3:0]   in_rdy;
    logic [3:0]   in_done;
    logic         out_vld;
    logic [63:0]  out_data;
    logic [1:0]   out_src;
    logic         out_rdy;
    logic         all_done;

    int n_checks = 0;
    int n_errs   = 0;

    cpu_data_arbiter #(.NUM_CPU(4), .FIFO_DEPTH(4), .DATA_W(64)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (in_vld),
        .in_data  (in_data),
        .in_rdy   (in_rdy),
        .in_done  (in_done),
        .out_vld  (out_vld),
        .out_data (out_data),
        .out_src  (out_src),
        .out_rdy  (out_rdy),
        .all_done (all_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int cpu, input logic [63:0] w);
        in_data[cpu*64 +: 64] = w;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        in_vld  = '0;
        in_done = '0;
        out_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    function automatic logic [63:0] bp_word(input int k);
        return 64'hC2C2_0000_0000_0000 + 64'(k);
    endfunction

    function automatic logic [63:0] st_word(input int k);
        return 64'h1100_0000_0000_0000 + 64'(k);
    endfunction

    initial begin
        logic r;
        int   k, n, sent, rcv, gaps, lows, bad_src, bad_data;
        bit   got_drop;

        rst_n   = 1'b0;
        in_vld  = '0;
        in_data = '0;
        in_done = '0;
        out_rdy = 1'b0;

        // Reset values
        step();
        chk("rst_out_vld", 64'(out_vld), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_src", 64'(out_src), 64'd0);
        chk("rst_all_done", 64'(all_done), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("rst_in_rdy", 64'(in_rdy), 64'hF);

        // Single word latency
        out_rdy   = 1'b1;
        in_vld[0] = 1'b1;
        set_word(0, 64'hDEAD_BEEF_0000_0001);
        step();
        in_vld = '0;
        chk("single_not_yet", 64'(out_vld), 64'd0);
        step();
        chk("single_vld", 64'(out_vld), 64'd1);
        chk("single_data", out_data, 64'hDEAD_BEEF_0000_0001);
        chk("single_src", 64'(out_src), 64'd0);
        step();
        chk("single_gone", 64'(out_vld), 64'd0);

        // Round-robin with all cpus preloaded
        do_reset();
        out_rdy = 1'b0;
        in_vld  = 4'hF;
        for (int i = 0; i < 4; i++) set_word(i, 64'(i * 16));
        step();
        for (int i = 0; i < 4; i++) set_word(i, 64'(i * 16 + 1));
        step();
        in_vld  = '0;
        out_rdy = 1'b1;
        for (int j = 0; j < 8; j++) begin
            chk("rr_vld", 64'(out_vld), 64'd1);
            chk("rr_src", 64'(out_src), 64'(j % 4));
            chk("rr_data", out_data, 64'((j % 4) * 16 + j / 4));
            step();
        end
        chk("rr_empty", 64'(out_vld), 64'd0);

        // Backpressure fills cpu2's FIFO
        do_reset();
        out_rdy   = 1'b0;
        in_vld[2] = 1'b1;
        k = 0;
        set_word(2, bp_word(0));
        for (int c = 0; c < 12; c++) begin
            r = in_rdy[2];
            step();
            if (r) begin
                k++;
                set_word(2, bp_word(k));
            end
        end
        chk("bp_accepted", 64'(k), 64'd5);
        chk("bp_in_rdy_low", 64'(in_rdy[2]), 64'd0);
        for (int c = 0; c < 10; c++) begin
            chk("bp_hold_vld", 64'(out_vld), 64'd1);
            chk("bp_hold_data", out_data, bp_word(0));
            step();
        end
        out_rdy = 1'b1;
        n = 0;
        for (int c = 0; c < 30 && n < 6; c++) begin
            r = in_rdy[2];
            if (out_vld) begin
                chk("bp_drain_data", out_data, bp_word(n));
                chk("bp_drain_src", 64'(out_src), 64'd2);
                n++;
            end
            step();
            if (r && in_vld[2]) in_vld[2] = 1'b0;
        end
        chk("bp_drain_count", 64'(n), 64'd6);
        chk("bp_drained", 64'(out_vld), 64'd0);

        // Streaming: push and pop on the same FIFO every cycle
        out_rdy = 1'b1;
        sent = 0; rcv = 0; gaps = 0; lows = 0; bad_src = 0; bad_data = 0;
        for (int c = 0; c < 140 && rcv < 100; c++) begin
            if (sent < 100) begin
                in_vld[1] = 1'b1;
                set_word(1, st_word(sent));
                if (!in_rdy[1]) lows++;
            end else begin
                in_vld[1] = 1'b0;
            end
            r = in_rdy[1];
            if (out_vld) begin
                if (out_data !== st_word(rcv)) bad_data++;
                if (out_src !== 2'd1) bad_src++;
                rcv++;
            end else if (rcv > 0) begin
                gaps++;
            end
            step();
            if (in_vld[1] && r) sent++;
        end
        in_vld = '0;
        chk("st_count", 64'(rcv), 64'd100);
        chk("st_gaps", 64'(gaps), 64'd0);
        chk("st_rdy_low", 64'(lows), 64'd0);
        chk("st_bad_src", 64'(bad_src), 64'd0);
        chk("st_bad_data", 64'(bad_data), 64'd0);

        // Done aggregation
        do_reset();
        out_rdy = 1'b0;
        for (int j = 0; j < 3; j++) begin
            in_vld = 4'b1000;
            set_word(3, 64'h3D00 + 64'(j));
            step();
        end
        in_vld  = '0;
        in_done = 4'b1111;
        step();
        in_done = 4'b1000;
        step();
        step();
        chk("done_pending", 64'(all_done), 64'd0);
        out_rdy  = 1'b1;
        n        = 0;
        got_drop = 1'b0;
        for (int c = 0; c < 20 && !got_drop; c++) begin
            if (out_vld) begin
                chk("done_drain_data", out_data, 64'h3D00 + 64'(n));
                chk("done_while_vld", 64'(all_done), 64'd0);
                n++;
                step();
            end else begin
                got_drop = 1'b1;
            end
        end
        chk("done_drop_seen", 64'(got_drop), 64'd1);
        chk("done_drain_count", 64'(n), 64'd3);
        chk("done_at_drop", 64'(all_done), 64'd0);
        step();
        chk("done_set", 64'(all_done), 64'd1);
        in_vld[0] = 1'b1;
        set_word(0, 64'h0E);
        if (all_done) $display("note: cpu0 pushes after all_done (cpu protocol violation)");
        step();
        in_vld = '0;
        step();
        chk("done_dropped", 64'(all_done), 64'd0);
        chk("done_late_vld", 64'(out_vld), 64'd1);
        chk("done_late_src", 64'(out_src), 64'd0);
        chk("done_late_data", out_data, 64'h0E);
        in_done = '0;

        // Reset mid-operation
        step();
        out_rdy = 1'b0;
        in_vld  = 4'hF;
        for (int i = 0; i < 4; i++) set_word(i, 64'h5100 + 64'(i));
        step();
        step();
        in_vld = '0;
        chk("mid_vld_before", 64'(out_vld), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", 64'(out_vld), 64'd0);
        chk("mid_rst_done", 64'(all_done), 64'd0);
        chk("mid_rst_data", out_data, 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("mid_in_rdy", 64'(in_rdy), 64'hF);
        chk("mid_no_stale", 64'(out_vld), 64'd0);
        out_rdy = 1'b1;
        in_vld  = 4'hF;
        for (int i = 0; i < 4; i++) set_word(i, 64'hA0 + 64'(i));
        step();
        in_vld = '0;
        chk("mid_post_idle", 64'(out_vld), 64'd0);
        step();
        for (int i = 0; i < 4; i++) begin
            chk("mid_post_vld", 64'(out_vld), 64'd1);
            chk("mid_post_src", 64'(out_src), 64'(i));
            chk("mid_post_data", out_data, 64'hA0 + 64'(i));
            step();
        end
        chk("mid_post_empty", 64'(out_vld), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/cpu_data_arbiter.md
Name: cpu_data_arbiter

Overview:
- Shares the single client data channel (the path to the DPI send call) between NUM_CPU cpu instances, so several cores can run inside one top-level simulation.
- Each cpu pushes 64-bit words into its own small FIFO.
- A round-robin scheduler drains the FIFOs into one registered valid/ready output, tagged with the source cpu index.
- It also aggregates the per-cpu transactions_done flags into one all_done, which the top level waits on before $finish.

Parameters:
- NUM_CPU, 4: number of requesting cpus; range 2..16.
- FIFO_DEPTH, 4: entries per cpu FIFO; power of 2, at least 2.
- DATA_W, 64: data word width.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- in_vld  in  NUM_CPU  per-cpu data valid.
- in_data  in  NUM_CPU*DATA_W  per-cpu data; cpu i occupies bits [i*DATA_W +: DATA_W].
- in_rdy  out  NUM_CPU  per-cpu FIFO not full.
- in_done  in  NUM_CPU  per-cpu transactions_done level.
- out_vld  out  1  output word valid.
- out_data  out  DATA_W  output word.
- out_src  out  SRC_W  index of the cpu that produced out_data; SRC_W = max(1, $clog2(NUM_CPU)).
- out_rdy  in  1  consumer accepts the word this cycle.
- all_done  out  1  all cpus done and the block fully drained.

Behaviour:
- Reset (async assert, sync deassert handled at top level):
  - All FIFOs empty; rr_ptr = NUM_CPU-1, so cpu0 has first priority.
  - Outputs: out_vld=0, out_data=0, out_src=0, all_done=0, done_seen=0.
  - in_rdy goes all-ones on the first cycle after reset release.
- Reset mid-operation: all queued and in-flight words are discarded, with no partial output.
- Push:
  - in_rdy[i] = !full[i]. It is combinational from the FIFO count only and does not depend on a same-cycle pop.
  - A word is written when in_vld[i] && in_rdy[i] at posedge.
  - in_vld[i] while full is ignored; the word is not stored and the cpu must hold it.
- Output register:
  - Load enable = !out_vld || out_rdy.
  - On load, the scheduler picks the first non-empty FIFO scanning from rr_ptr+1 upward, modulo NUM_CPU.
  - The picked FIFO pops its head into out_data/out_src, out_vld is set to 1, and rr_ptr takes the picked index.
  - Load enable with no FIFO non-empty: out_vld goes to 0, and out_data/out_src hold their values.
- Stability and throughput:
  - While out_vld && !out_rdy, out_vld, out_data and out_src are held stable and no FIFO pops.
  - With out_rdy held high, one word leaves per cycle.
- Latency: a word pushed at edge E0 into an empty system shows out_vld=1 after edge E0+1, a 1-cycle FIFO-to-output stage.
- Simultaneous push and pop on the same FIFO:
  - Allowed when not full; the count is unchanged.
  - Full FIFO: pop only, because in_rdy was 0.
- Ordering: per-cpu FIFO order is preserved; there is no ordering guarantee across cpus beyond round-robin.
- Fairness: with k cpus continuously non-empty, each is granted exactly once every k loads.
- Wrap-around:
  - FIFO pointers are log2(FIFO_DEPTH) bits, plus one extra bit for the full/empty distinction.
  - rr_ptr wraps from NUM_CPU-1 to 0.
- Done tracking:
  - done_seen[i] is sticky: set on in_done[i]=1 and cleared only by reset.
  - all_done is registered: the next value is &done_seen && all FIFOs empty && !out_vld.
  - It is re-evaluated every cycle, so any later push drops it again.
  - A push after done is a cpu protocol violation; the bench flags it, and the RTL still accepts the word.

Decomposition:
- Package cpu_arb_pkg:
  - constant DATA_W_DEFAULT=64;
  - function src_width(n) returning max(1, $clog2(n));
  - typedef data_t = logic [63:0];
  - struct out_word_t {data_t data; logic [SRC_W-1:0] src}.
- Sub-module cpu_arb_fifo:
  - Synchronous FIFO, parameters DEPTH and WIDTH.
  - Ports clk, rst_n, push, wdata, pop, rdata (head, first-word-fall-through), full, empty.
  - cpu_data_arbiter instantiates it NUM_CPU times in a generate loop.
- The round-robin pick is a function in the top module.

Test Plan:
- Single word: after reset, cpu0 pushes 64'hDEAD_BEEF_0000_0001 with out_rdy=1 -> after edge E0+1, out_vld=1, out_data=64'hDEAD_BEEF_0000_0001, out_src=0; out_vld=0 on the next cycle.
- Round-robin: all 4 cpus preloaded with 2 words each (cpu i: 64'hi0, 64'hi1), out_rdy=1 -> out_src sequence 0,1,2,3,0,1,2,3 and per-cpu data in order.
- Backpressure and full:
  - Stimulus: out_rdy=0; cpu2 pushes 6 words.
  - Expect: 1 word sits in the output register and 4 in the FIFO; in_rdy[2]=0 after 5 accepted pushes.
  - The 6th word stays held, and out_data stays stable for 10 cycles.
  - Raising out_rdy drains all 6 in order.
- Same-cycle push and pop: cpu1 streams a word every cycle with out_rdy=1 for 100 cycles -> in_rdy[1] stays 1, 100 words out, out_src=1 throughout, no gaps after the first.
- Done aggregation:
  - Stimulus: cpus 0-2 assert in_done as pulses; cpu3 still has 3 words queued and asserts in_done.
  - Expect: all_done=0 until the last word is accepted, then 1 one cycle after out_vld drops.
  - A further push by cpu0 drops all_done.
- Reset mid-operation: rst_n low for 3 cycles while all FIFOs are half full and out_vld=1 -> out_vld=0 and all_done=0 immediately (asynchronous); after release, the first grant goes to cpu0 and no stale word appears.
